// File: rtl/rgbw_frame_decoder_pkg.sv
// Shared constants and FSM encoding for the RGBW command-frame decoder.
package rgbw_frame_decoder_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 9;
  localparam int         PAYLOAD_LEN   = 7;

  localparam logic [2:0] IDX_MODE  = 3'd0;
  localparam logic [2:0] IDX_LINT  = 3'd1;
  localparam logic [2:0] IDX_RED   = 3'd2;
  localparam logic [2:0] IDX_GREEN = 3'd3;
  localparam logic [2:0] IDX_BLUE  = 3'd4;
  localparam logic [2:0] IDX_WHITE = 3'd5;
  localparam logic [2:0] IDX_CIDX  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CKSUM   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/rgbw_frame_decoder_rdy_edge_detect.sv
// Rising-edge detector on the SPI byte-ready level: one accepted byte per 0->1 transition.
module rdy_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic rdy_in,
  output logic rdy_rise_o
);

  logic rdy_q;

  always_ff @(posedge clk) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= rdy_in;
  end

  assign rdy_rise_o = rdy_in & ~rdy_q;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Assembles SYNC+7 payload+XOR-checksum frames from the SPI byte stream and
// commits the payload atomically to the colour-generator registers.
module rgbw_frame_decoder
  import rgbw_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_half,
  input  logic       cs,
  input  logic       rdy_in,
  input  logic [7:0] data_in,
  output logic [7:0] mode_out,
  output logic [7:0] lint_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic [7:0] white_out,
  output logic [7:0] colorIdx_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] TIMER_RELOAD = 8'(TIMEOUT_TICKS);

  state_e     state_q, state_d;
  logic       byte_acc;
  logic       in_frame;
  logic       tmo;
  logic       start, load, commit, err_set;
  logic [2:0] idx_q;
  logic [7:0] acc_q;
  logic [7:0] timer_q;
  logic [7:0] err_cnt_q;
  logic       frame_ok_q, frame_err_q;
  logic [7:0] shadow_q [PAYLOAD_LEN];
  logic [7:0] out_q    [PAYLOAD_LEN];

  rdy_edge_detect u_rdy_edge (
    .clk        (clk),
    .reset      (reset),
    .rdy_in     (rdy_in),
    .rdy_rise_o (byte_acc)
  );

  assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
  // The timer expires on the tick that would take it to zero.
  assign tmo = in_frame && clk_half && (timer_q <= 8'd1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Priority inside a frame: cs abort, then accepted byte, then timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_acc && (data_in == SYNC_BYTE)) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (cs)                                  state_d = ST_IDLE;
        else if (byte_acc && idx_q == IDX_CIDX)  state_d = ST_CKSUM;
        else if (!byte_acc && tmo)               state_d = ST_IDLE;
      end
      ST_CKSUM: begin
        if (cs)                                  state_d = ST_IDLE;
        else if (byte_acc)                       state_d = (data_in == acc_q) ? ST_COMMIT : ST_IDLE;
        else if (tmo)                            state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    load    = 1'b0;
    commit  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE:    start = byte_acc && (data_in == SYNC_BYTE);
      ST_PAYLOAD: begin
        load    = !cs && byte_acc;
        err_set = cs || (!byte_acc && tmo);
      end
      ST_CKSUM:   err_set = cs || (byte_acc && (data_in != acc_q)) || (!byte_acc && tmo);
      ST_COMMIT:  commit = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      acc_q       <= '0;
      timer_q     <= '0;
      err_cnt_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      frame_ok_q  <= commit;
      frame_err_q <= err_set;
      if (err_set && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;

      if (byte_acc)                                     timer_q <= TIMER_RELOAD;
      else if (state_q != ST_IDLE && clk_half && timer_q != 8'd0) timer_q <= timer_q - 8'd1;

      if (start) begin
        acc_q <= SYNC_BYTE;
        idx_q <= '0;
      end
      if (load) begin
        shadow_q[idx_q] <= data_in;
        acc_q           <= acc_q ^ data_in;
        idx_q           <= 3'(idx_q + 3'd1);
      end
      if (commit) begin
        for (int i = 0; i < PAYLOAD_LEN; i++) out_q[i] <= shadow_q[i];
      end
    end
  end

  assign mode_out     = out_q[IDX_MODE];
  assign lint_out     = out_q[IDX_LINT];
  assign red_out      = out_q[IDX_RED];
  assign green_out    = out_q[IDX_GREEN];
  assign blue_out     = out_q[IDX_BLUE];
  assign white_out    = out_q[IDX_WHITE];
  assign colorIdx_out = out_q[IDX_CIDX];
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Bench for rgbw_frame_decoder: byte-level frame model with an expected-commit queue.
module tb_rgbw_frame_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_half = 1'b0;
  logic       cs;
  logic       rdy_in;
  logic [7:0] data_in;
  logic [7:0] mode_out, lint_out, red_out, green_out, blue_out, white_out, colorIdx_out;
  logic       frame_ok, frame_err;
  logic [7:0] err_cnt;

  rgbw_frame_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .clk_half     (clk_half),
    .cs           (cs),
    .rdy_in       (rdy_in),
    .data_in      (data_in),
    .mode_out     (mode_out),
    .lint_out     (lint_out),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .white_out    (white_out),
    .colorIdx_out (colorIdx_out),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    clk_half = ~clk_half;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [55:0] exp_q[$];
  int          lat_q[$];
  logic [55:0] exp_last = '0;
  bit          open = 1'b0;
  logic [7:0]  fb[$];
  int          exp_err  = 0;
  int          err_base = 0;
  int          seen_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] outs();
    return {mode_out, lint_out, red_out, green_out, blue_out, white_out, colorIdx_out};
  endfunction

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Frame model: bytes outside a frame are ignored unless SYNC; after 9 bytes
  // the XOR of the first eight decides between commit and error.
  function automatic void model_byte(input logic [7:0] b, input int c);
    logic [7:0] x;
    if (!open) begin
      if (b == 8'hA5) begin
        open = 1'b1;
        fb.delete();
        fb.push_back(b);
      end
    end else begin
      fb.push_back(b);
      if (fb.size() == 9) begin
        x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= fb[i];
        if (x == fb[8]) begin
          exp_last = {fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7]};
          exp_q.push_back(exp_last);
          lat_q.push_back(c + 2);
        end else begin
          exp_err++;
        end
        open = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (frame_ok) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame_ok", 1, 0);
      end else begin
        check("commit_data", outs(), exp_q.pop_front());
        check("commit_latency", cyc, lat_q.pop_front());
      end
    end
    if (frame_err) seen_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int c;
    @(posedge clk); #1;
    data_in = b;
    rdy_in  = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    rdy_in = 1'b0;
    model_byte(b, c);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_held(input logic [7:0] b, input int n);
    int c;
    @(posedge clk); #1;
    data_in = b;
    rdy_in  = 1'b1;
    c = cyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      data_in = 8'($urandom_range(0, 255));
    end
    rdy_in = 1'b0;
    model_byte(b, c);
  endtask

  task automatic send_frame(input logic [55:0] p, input bit corrupt, input int gap);
    logic [7:0] f[9];
    logic [7:0] x;
    f[0] = 8'hA5;
    for (int i = 0; i < 7; i++) f[i+1] = p[55-8*i -: 8];
    x = 8'h00;
    for (int i = 0; i < 8; i++) x ^= f[i];
    f[8] = corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
    for (int i = 0; i < 9; i++) send_byte(f[i], gap);
  endtask

  task automatic cs_abort();
    @(posedge clk); #1;
    cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
    if (open) begin
      exp_err++;
      open = 1'b0;
    end
  endtask

  task automatic checkpoint(input string tag);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_err_pulses"}, seen_err, exp_err);
    check({tag, "_err_cnt"}, err_cnt, sat255(exp_err - err_base));
    check({tag, "_outputs"}, outs(), exp_last);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [55:0] FRAME_A = 56'h01_80_FF_00_10_20_03;

  initial begin
    logic [55:0] p;
    logic [7:0]  j;
    reset = 1'b1; cs = 1'b0; rdy_in = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 56'h0);
    check("reset_flags", {frame_ok, frame_err, err_cnt}, 10'h0);

    send_frame(FRAME_A, 1'b0, 1);
    checkpoint("valid_a");
    check("valid_a_vector", outs(), FRAME_A);

    send_frame(56'h02_11_22_33_44_55_66, 1'b1, 1);
    checkpoint("bad_ck");

    send_byte(8'h3C, 1);
    send_byte(8'h7E, 1);
    send_frame(FRAME_A, 1'b0, 0);
    checkpoint("junk_then_valid");

    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h80, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("timeout_not_early", seen_err, exp_err);
    repeat (600) @(posedge clk);
    exp_err++;
    open = 1'b0;
    checkpoint("timeout");
    send_frame(56'h05_06_07_08_09_0A_0B, 1'b0, 2);
    checkpoint("after_timeout");

    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    cs_abort();
    checkpoint("cs_abort");
    cs_abort();
    checkpoint("cs_idle");

    send_byte(8'hA5, 1);
    send_held(8'h01, 8);
    send_byte(8'h80, 1); send_byte(8'hFF, 1); send_byte(8'h00, 1);
    send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h03, 1);
    send_byte(8'hE8, 1);
    checkpoint("rdy_held");

    for (int k = 0; k < 40; k++) begin
      for (int m = $urandom_range(0, 2); m > 0; m--) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, $urandom_range(0, 2));
      end
      p = {$urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'hA5, 0);
        send_byte(p[7:0], 0);
        cs_abort();
      end else begin
        send_frame(p, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      end
      if (k % 10 == 9) checkpoint("random");
    end

    for (int k = 0; k < 300; k++) send_frame({$urandom(), $urandom()}, 1'b1, 0);
    checkpoint("saturate");

    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    open     = 1'b0;
    exp_last = '0;
    err_base = exp_err;
    checkpoint("reset_mid_frame");
    send_frame(FRAME_A, 1'b0, 1);
    checkpoint("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgbw_frame_decoder.md
Name: rgbw_frame_decoder

Overview:
Consumes the byte stream from the SPI slave receiver (data byte plus ready level) and assembles fixed-length command frames. It validates each frame's sync byte and XOR checksum. On a valid frame it commits mode, intensity, RGBW and colour-index registers atomically to the colour generator. It sits between the SPI slave and the colour generator and runs on the system clock, gated by the shared prescaler enable.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame.
TIMEOUT_TICKS, 255, number of clk_half ticks with no accepted byte before an open frame is abandoned; range 1..255.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
clk_half  in  1  single-cycle enable strobe from the clock divider; advances the timeout counter only.
cs  in  1  SPI chip select, active low, already synchronised by the receiver.
rdy_in  in  1  byte-ready level from the SPI slave; a 0->1 transition marks a new byte.
data_in  in  8  received byte; valid in the cycle the rdy_in rising edge is detected.
mode_out  out  8  committed mode register.
lint_out  out  8  committed light intensity.
red_out  out  8  committed red level.
green_out  out  8  committed green level.
blue_out  out  8  committed blue level.
white_out  out  8  committed white level.
colorIdx_out  out  8  committed colour index.
frame_ok  out  1  one-cycle pulse in the cycle the outputs update.
frame_err  out  1  one-cycle pulse on checksum error, timeout or cs abort.
err_cnt  out  8  saturating count of frame_err pulses.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Shadow registers, index, checksum accumulator, timer and the rdy_in edge register are cleared.
- Byte acceptance: register rdy_in. A byte is accepted when rdy_in=1 and the registered value is 0, so at most one byte is accepted per rising edge. data_in is sampled in that same cycle.
- Frame format: SYNC, mode, lint, red, green, blue, white, colorIdx, CK. CK is the XOR of the preceding 8 bytes.
- FSM states:
  - IDLE: an accepted byte equal to SYNC_BYTE sets acc=SYNC_BYTE and idx=0, then moves to PAYLOAD. Any other byte is ignored with no error.
  - PAYLOAD: each accepted byte is written to shadow[idx], XORed into acc, and increments idx. After idx 6 is written, move to CKSUM.
  - CKSUM: if the accepted byte equals acc, move to COMMIT. Otherwise pulse frame_err and return to IDLE.
  - COMMIT: in one cycle, copy all 7 shadows to the outputs, pulse frame_ok, and return to IDLE. Any byte edge arriving in this cycle is dropped.
- Latency: outputs and frame_ok appear 2 clk cycles after the cycle in which the CK byte is accepted.
- Timeout:
  - The timer is reloaded to TIMEOUT_TICKS on every accepted byte.
  - Outside IDLE, it decrements on each clk_half.
  - When it reaches 0 outside IDLE: pulse frame_err and go to IDLE.
  - If the timer expires in the same cycle a byte is accepted, the byte wins: reload and process the byte, no error.
- cs abort:
  - cs=1 in PAYLOAD or CKSUM: pulse frame_err and go to IDLE; a byte accepted in that cycle is discarded.
  - cs=1 in IDLE: no effect.
  - cs is not checked in COMMIT.
- Committed outputs change only in COMMIT. Aborted or errored frames leave the previous values intact.
- err_cnt increments on every frame_err pulse and saturates at 8'hFF.
- Reset asserted mid-frame discards the frame without a frame_err pulse.
- A SYNC_BYTE value inside the payload is treated as data; there is no resynchronisation.

Decomposition:
- Shared package holds:
  - SYNC_BYTE default.
  - FRAME_LEN=9 and PAYLOAD_LEN=7.
  - Payload index constants IDX_MODE..IDX_CIDX (0..6).
  - FSM state encoding (IDLE, PAYLOAD, CKSUM, COMMIT, 2 bits).
- One natural sub-module: rdy_edge_detect, the rdy_in rising-edge detector (1 flop plus AND).
- Timer, checksum and shadow registers stay inline.

Test Plan:
- Valid frame A5,01,80,FF,00,10,20,03,E8 sent with cs=0 -> frame_ok pulse once. Outputs become mode=01, lint=80, red=FF, green=00, blue=10, white=20, colorIdx=03. err_cnt=0.
- Same frame with CK=E9 -> frame_err pulse. Outputs keep their prior values. err_cnt=1.
- Bytes 3C,7E, then the valid frame -> leading bytes ignored with no error. The frame commits as in scenario 1.
- A5,01,80 then no rdy edge for 256 clk_half ticks -> frame_err at the tick where the timer reaches 0, FSM back in IDLE. A following valid frame commits.
- A5,01 then cs=1 -> frame_err in the cs=1 cycle. rdy_in held high continuously yields only one accepted byte.
- 300 consecutive bad-CK frames -> err_cnt saturates at FF. Reset mid-frame -> all outputs 0, no pulse.
